// File: rtl/lbm_dist_bank.sv
// Ping-pong bank for Q distribution channels. The solver reads "current" and writes "next";
// a swap exchanges the roles, and an INIT sweep fills both halves with INIT_VALUES.
module lbm_dist_bank #(
    parameter int Q          = 9,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2500,
    parameter int ADDR_WIDTH = 12,
    parameter int CH_WIDTH   = 4,
    parameter logic [Q*DATA_WIDTH-1:0] INIT_VALUES = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init_req,
    output logic                    init_busy,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic                    bank_sel,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [Q*DATA_WIDTH-1:0] rd_data,
    output logic                    rd_valid,
    input  logic [Q-1:0]            wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [Q*DATA_WIDTH-1:0] wr_data,
    input  logic                    host_req,
    input  logic [CH_WIDTH-1:0]     host_ch,
    input  logic [ADDR_WIDTH-1:0]   host_addr,
    output logic                    host_grant,
    output logic [DATA_WIDTH-1:0]   host_data,
    output logic                    host_valid,
    output logic                    oob_err
);
    localparam int LAST_INT = DEPTH - 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = LAST_INT[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = DEPTH[ADDR_WIDTH:0];
    localparam logic [CH_WIDTH:0]     Q_LIM     = Q[CH_WIDTH:0];

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t state_reg, state_next;

    logic [ADDR_WIDTH-1:0]   counter_reg;
    logic                    bank_sel_reg, swap_ack_reg, swap_pend_reg, oob_err_reg;
    logic                    rd_valid_reg, host_valid_reg;
    logic [Q*DATA_WIDTH-1:0] rd_data_reg;
    logic [DATA_WIDTH-1:0]   host_data_reg;

    logic is_run, rd_ok, wr_ok, host_ok, raddr_ok, oob_hit;
    logic [ADDR_WIDTH-1:0]   raddr, raddr_safe, waddr;
    logic [CH_WIDTH-1:0]     ch_safe;
    logic [DATA_WIDTH-1:0]   cur_word [Q];
    logic [Q*DATA_WIDTH-1:0] cur_packed;

    assign is_run     = (state_reg == ST_RUN);
    assign rd_ok      = ({1'b0, rd_addr} < DEPTH_LIM);
    assign wr_ok      = ({1'b0, wr_addr} < DEPTH_LIM);
    assign host_ok    = ({1'b0, host_addr} < DEPTH_LIM) && ({1'b0, host_ch} < Q_LIM);
    // One shared read port per half: the host only gets it when the solver is idle.
    assign raddr      = rd_en ? rd_addr : host_addr;
    assign raddr_ok   = rd_en ? rd_ok : host_ok;
    assign raddr_safe = raddr_ok ? raddr : '0;
    assign ch_safe    = host_ok ? host_ch : '0;
    assign waddr      = is_run ? wr_addr : counter_reg;

    generate
        for (genvar gi = 0; gi < Q; gi++) begin : g_ch
            logic [DATA_WIDTH-1:0] mem0 [DEPTH];
            logic [DATA_WIDTH-1:0] mem1 [DEPTH];
            logic                  we0, we1;
            logic [DATA_WIDTH-1:0] wdata;

            // The next half is the one bank_sel does not point at.
            assign we0   = ~is_run | (wr_en[gi] & wr_ok & bank_sel_reg);
            assign we1   = ~is_run | (wr_en[gi] & wr_ok & ~bank_sel_reg);
            assign wdata = is_run ? wr_data[gi*DATA_WIDTH +: DATA_WIDTH]
                                  : INIT_VALUES[gi*DATA_WIDTH +: DATA_WIDTH];

            always_ff @(posedge clk) begin
                if (we0) mem0[waddr] <= wdata;
                if (we1) mem1[waddr] <= wdata;
            end

            assign cur_word[gi] = bank_sel_reg ? mem1[raddr_safe] : mem0[raddr_safe];
            assign cur_packed[gi*DATA_WIDTH +: DATA_WIDTH] = cur_word[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_INIT;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INIT: if (!init_req && counter_reg == LAST_ADDR) state_next = ST_RUN;
            ST_RUN:  if (init_req) state_next = ST_INIT;
            default: state_next = ST_INIT;
        endcase
    end

    always_comb begin
        init_busy  = (state_reg == ST_INIT);
        host_grant = host_req & (state_reg == ST_RUN) & ~rd_en;
    end

    always_comb begin
        if (is_run)
            oob_hit = (rd_en & ~rd_ok) | ((|wr_en) & ~wr_ok) | (host_grant & ~host_ok);
        else
            oob_hit = rd_en | (|wr_en);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter_reg    <= '0;
            bank_sel_reg   <= 1'b0;
            swap_ack_reg   <= 1'b0;
            swap_pend_reg  <= 1'b0;
            oob_err_reg    <= 1'b0;
            rd_valid_reg   <= 1'b0;
            host_valid_reg <= 1'b0;
            rd_data_reg    <= '0;
            host_data_reg  <= '0;
        end else begin
            if (init_req || is_run || counter_reg == LAST_ADDR) counter_reg <= '0;
            else counter_reg <= counter_reg + ADDR_WIDTH'(1);

            // Swaps requested during INIT collapse into one that fires on the first RUN cycle.
            swap_ack_reg <= 1'b0;
            if (is_run && (swap_req || swap_pend_reg)) begin
                bank_sel_reg  <= ~bank_sel_reg;
                swap_ack_reg  <= 1'b1;
                swap_pend_reg <= 1'b0;
            end else if (!is_run && swap_req) begin
                swap_pend_reg <= 1'b1;
            end

            if (is_run && init_req) oob_err_reg <= 1'b0;
            else if (oob_hit)       oob_err_reg <= 1'b1;

            rd_valid_reg <= is_run & rd_en;
            if (is_run && rd_en) rd_data_reg <= rd_ok ? cur_packed : '0;

            host_valid_reg <= host_grant;
            if (host_grant) host_data_reg <= host_ok ? cur_word[ch_safe] : '0;
        end
    end

    assign bank_sel   = bank_sel_reg;
    assign swap_ack   = swap_ack_reg;
    assign oob_err    = oob_err_reg;
    assign rd_valid   = rd_valid_reg;
    assign rd_data    = rd_data_reg;
    assign host_valid = host_valid_reg;
    assign host_data  = host_data_reg;
endmodule

// File: tb/tb_lbm_dist_bank.sv
// Directed bench for lbm_dist_bank: INIT sweep length, ping-pong swap semantics,
// partial writes, host arbitration, out-of-range handling and pending swaps.
module tb_lbm_dist_bank;
    localparam int Q = 9, DW = 16, DEPTH = 2500, AW = 12, CW = 4, W = Q*DW;
    localparam logic [W-1:0] IV = {16'hA008, 16'hA007, 16'hA006, 16'hA005, 16'hA004,
                                   16'hA003, 16'hA002, 16'hA001, 16'hA000};

    logic          clk = 1'b0;
    logic          rst, init_req, init_busy, swap_req, swap_ack, bank_sel;
    logic          rd_en, rd_valid, host_req, host_grant, host_valid, oob_err;
    logic [AW-1:0] rd_addr, wr_addr, host_addr;
    logic [W-1:0]  rd_data, wr_data;
    logic [Q-1:0]  wr_en;
    logic [CW-1:0] host_ch;
    logic [DW-1:0] host_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lbm_dist_bank #(.Q(Q), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
                    .CH_WIDTH(CW), .INIT_VALUES(IV)) dut (
        .clk(clk), .rst(rst), .init_req(init_req), .init_busy(init_busy),
        .swap_req(swap_req), .swap_ack(swap_ack), .bank_sel(bank_sel),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .host_req(host_req), .host_ch(host_ch), .host_addr(host_addr),
        .host_grant(host_grant), .host_data(host_data), .host_valid(host_valid),
        .oob_err(oob_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
            $display("check %s ok obs=%0h", tag, obs);
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [AW-1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (init_busy && n < 3000) begin
            tick();
            n++;
        end
    endtask

    task automatic do_swap(input logic exp_sel);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("swap_ack_hi", W'(swap_ack), W'(1));
        chk("swap_sel", W'(bank_sel), W'(exp_sel));
        tick();
        chk("swap_ack_lo", W'(swap_ack), W'(0));
    endtask

    initial begin
        int n, acks;
        logic [W-1:0] kp, exp3;

        rst = 1'b0; init_req = 1'b0; swap_req = 1'b0; rd_en = 1'b0; rd_addr = '0;
        wr_en = '0; wr_addr = '0; wr_data = '0; host_req = 1'b0; host_ch = '0; host_addr = '0;
        for (int k = 0; k < Q; k++) kp[k*DW +: DW] = DW'(k + 1);
        exp3 = IV;
        exp3[2*DW +: DW] = 16'h0BEE;

        repeat (3) tick();
        chk("rst_busy", W'(init_busy), W'(1));
        chk("rst_sel", W'(bank_sel), W'(0));
        chk("rst_valids", W'({rd_valid, host_valid, swap_ack, oob_err}), W'(0));
        chk("rst_rd_data", rd_data, W'(0));
        chk("rst_host_data", W'(host_data), W'(0));

        rst = 1'b1;
        wait_init(n);
        chk("init_len", W'(n), W'(2500));

        // Both ends of the lattice in both halves hold the init values.
        rd(0);
        chk("rd0_valid", W'(rd_valid), W'(1));
        chk("rd0_h0", rd_data, IV);
        rd(12'd2499);
        chk("rd2499_h0", rd_data, IV);
        do_swap(1'b1);
        rd(0);
        chk("rd0_h1", rd_data, IV);
        rd(12'd2499);
        chk("rd2499_h1", rd_data, IV);
        do_swap(1'b0);

        // Full write to node 17 with a concurrent swap and a read of the old current half.
        wr_en = 9'h1FF; wr_addr = 12'd17; wr_data = kp;
        swap_req = 1'b1; rd_en = 1'b1; rd_addr = 12'd17;
        tick();
        wr_en = '0; swap_req = 1'b0; rd_en = 1'b0;
        chk("wsw_ack", W'(swap_ack), W'(1));
        chk("wsw_sel", W'(bank_sel), W'(1));
        chk("wsw_rd_old", rd_data, IV);
        tick();
        chk("wsw_ack_one", W'(swap_ack), W'(0));
        rd(12'd17);
        chk("rd17_new", rd_data, kp);

        // Single-channel write to node 5.
        wr_en = 9'h004; wr_addr = 12'd5; wr_data = {Q{16'h5555}};
        wr_data[2*DW +: DW] = 16'h0BEE;
        tick();
        wr_en = '0;
        do_swap(1'b0);
        rd(12'd5);
        chk("rd5_partial", rd_data, exp3);

        // Solver always wins the shared read port.
        rd_en = 1'b1; rd_addr = 12'd5; host_req = 1'b1; host_ch = 4'd2; host_addr = 12'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("grant_blocked", W'(host_grant), W'(0));
            tick();
        end
        chk("blk_rd_valid", W'(rd_valid), W'(1));
        chk("blk_host_valid", W'(host_valid), W'(0));
        rd_en = 1'b0;
        #1;
        chk("grant_free", W'(host_grant), W'(1));
        tick();
        host_req = 1'b0;
        chk("host_valid", W'(host_valid), W'(1));
        chk("host_data", W'(host_data), W'(16'h0BEE));
        tick();
        chk("host_valid_drop", W'(host_valid), W'(0));
        chk("host_data_hold", W'(host_data), W'(16'h0BEE));

        // Out-of-range solver and host reads.
        rd(12'd2500);
        chk("oob_rd_valid", W'(rd_valid), W'(1));
        chk("oob_rd_data", rd_data, W'(0));
        chk("oob_flag", W'(oob_err), W'(1));
        host_req = 1'b1; host_ch = 4'd9; host_addr = 12'd0;
        tick();
        host_req = 1'b0;
        chk("oob_host_valid", W'(host_valid), W'(1));
        chk("oob_host_data", W'(host_data), W'(0));

        // Re-init clears the flag; two swap pulses during INIT collapse to one.
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        chk("reinit_oob_clr", W'(oob_err), W'(0));
        chk("reinit_busy", W'(init_busy), W'(1));
        swap_req = 1'b1; tick(); swap_req = 1'b0; tick();
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        acks = 0;
        n = 0;
        while (init_busy && n < 3000) begin
            if (swap_ack) acks++;
            tick();
            n++;
        end
        chk("reinit_len", W'(n), W'(2497));
        chk("pend_no_ack_init", W'(acks), W'(0));
        chk("pend_sel_init", W'(bank_sel), W'(0));
        tick();
        chk("pend_ack", W'(swap_ack), W'(1));
        chk("pend_sel", W'(bank_sel), W'(1));
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (swap_ack) acks++;
        end
        chk("pend_single", W'(acks), W'(0));
        rd(12'd17);
        chk("reinit_rd17", rd_data, IV);

        // Accesses during INIT are ignored but flagged; reset aborts the sweep.
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        rd_en = 1'b1; rd_addr = 12'd0; wr_en = 9'h001; wr_addr = 12'd3; host_req = 1'b1;
        #1;
        chk("init_no_grant", W'(host_grant), W'(0));
        tick();
        rd_en = 1'b0; wr_en = '0; host_req = 1'b0;
        chk("init_rd_valid", W'(rd_valid), W'(0));
        chk("init_oob", W'(oob_err), W'(1));
        chk("init_rd_hold", rd_data, IV);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", W'(init_busy), W'(1));
        chk("mid_rst_oob", W'(oob_err), W'(0));
        chk("mid_rst_sel", W'(bank_sel), W'(0));
        chk("mid_rst_rd", rd_data, W'(0));
        tick();
        rst = 1'b1;
        wait_init(n);
        chk("rst_init_len", W'(n), W'(2500));
        rd(12'd2499);
        chk("final_rd", rd_data, IV);
        host_req = 1'b1; host_ch = 4'd8; host_addr = 12'd2499;
        tick();
        host_req = 1'b0;
        chk("final_host", W'(host_data), W'(16'hA008));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
